// File: rtl/dvi_pattern_gen.sv
// dvi_pattern_gen
//   Programmable DVI/VGA timing generator with four selectable test patterns.
//   Frames run while `start` is high and are always completed whole; `mode`
//   and `fill` are captured at frame boundaries only.
//
// Ports
//   clock        pixel clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        level, high = keep producing frames
//   mode[1:0]    0 solid, 1 colour bars, 2 checkerboard, 3 horizontal gradient
//   fill         solid colour {R,G,B}
//   red/green/blue  pixel data, zero outside the active region
//   hsync_out/vsync sync outputs at SYNC_POL polarity
//   de           data enable (active region)
//   frame_start  one-cycle pulse coincident with pixel (0,0)
//
// Build option
//   DVI_PATTERN_SCROLL_EN : when defined, the pattern x coordinate is offset by
//   a per-frame counter so bars, checkerboard and gradient scroll left one
//   pixel per frame. Undefined: static patterns.
module dvi_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int COLOR_W  = 8,
   parameter int SYNC_POL = 0,
   parameter int CHK_LOG2 = 3
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic [3*COLOR_W-1:0]   fill,
   output logic [COLOR_W-1:0]     red,
   output logic [COLOR_W-1:0]     green,
   output logic [COLOR_W-1:0]     blue,
   output logic                   hsync_out,
   output logic                   vsync,
   output logic                   de,
   output logic                   frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CW_H    = $clog2(H_TOTAL);
   localparam int CW_V    = $clog2(V_TOTAL);
   localparam int CW0     = (CW_H > CW_V) ? CW_H : CW_V;
   // Counters are wide enough to index bit CHK_LOG2 of x and y directly.
   localparam int CW      = (CW0 > CHK_LOG2) ? CW0 : CHK_LOG2 + 1;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BPW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [CW-1:0]  H_LAST    = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0]  V_LAST    = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0]  X_LAST    = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0]  H_ACT     = CW'(H_ACTIVE);
   localparam logic [CW-1:0]  V_ACT     = CW'(V_ACTIVE);
   localparam logic [CW-1:0]  HS_BEG    = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0]  HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0]  VS_BEG    = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0]  VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [BPW-1:0] BPOS_LAST = BPW'(BAR_W - 1);
   localparam logic           SYNC_ACT  = (SYNC_POL != 0);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state;
   logic [CW-1:0]          h_p0, v_p0, x_p0;
   logic [2:0]             bidx_p0;
   logic [BPW-1:0]         bpos_p0;
   logic [1:0]             mode_sh;
   logic [3*COLOR_W-1:0]   fill_sh;

   logic [CW-1:0]          x_line;
   logic [2:0]             bidx_line;
   logic [BPW-1:0]         bpos_line;
   logic                   frame_wrap;

   logic                   run_p0, active_p0, hs_on_p0, vs_on_p0, fs_p0;
   logic [3*COLOR_W-1:0]   pix_p0;

   logic [COLOR_W-1:0]     red_p1, green_p1, blue_p1;
   logic                   vld_p1, hs_p1, vs_p1, fs_p1;

   // x advances modulo H_ACTIVE so a scrolled line wraps back to column 0.
   function automatic logic [CW-1:0] x_step(input logic [CW-1:0] x);
      return (x == X_LAST) ? '0 : x + CW'(1);
   endfunction

   // Bar index/position pair; the 3-bit index wraps 7 -> 0 naturally.
   function automatic logic [BPW+2:0] bar_step(input logic [2:0] idx,
                                               input logic [BPW-1:0] pos);
      if (pos == BPOS_LAST) return {idx + 3'd1, BPW'(0)};
      else                  return {idx, pos + BPW'(1)};
   endfunction

   // white, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [3*COLOR_W-1:0] bar_rgb(input logic [2:0] idx);
      return {{COLOR_W{~idx[1]}}, {COLOR_W{~idx[2]}}, {COLOR_W{~idx[0]}}};
   endfunction

   function automatic logic [3*COLOR_W-1:0] pattern(input logic [1:0]           m,
                                                    input logic [3*COLOR_W-1:0] f,
                                                    input logic [CW-1:0]        x,
                                                    input logic [CW-1:0]        y,
                                                    input logic [2:0]           bidx);
      case (m)
         2'd0:    return f;
         2'd1:    return bar_rgb(bidx);
         2'd2:    return (x[CHK_LOG2] ^ y[CHK_LOG2]) ? '0 : '1;
         default: return {3{COLOR_W'(x)}};
      endcase
   endfunction

   assign frame_wrap = (state == RUN) && (h_p0 == H_LAST) && (v_p0 == V_LAST);

`ifdef DVI_PATTERN_SCROLL_EN
   logic [CW-1:0]  off_p0;
   logic [2:0]     off_bidx_p0;
   logic [BPW-1:0] off_bpos_p0;

   // Each line starts at the frame's offset; at a frame wrap the next frame
   // already uses the advanced offset.
   always_comb begin
      x_line    = off_p0;
      bidx_line = off_bidx_p0;
      bpos_line = off_bpos_p0;
      if (frame_wrap) begin
         x_line                 = x_step(off_p0);
         {bidx_line, bpos_line} = bar_step(off_bidx_p0, off_bpos_p0);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         off_p0      <= '0;
         off_bidx_p0 <= '0;
         off_bpos_p0 <= '0;
      end else if (state == IDLE) begin
         off_p0      <= '0;
         off_bidx_p0 <= '0;
         off_bpos_p0 <= '0;
      end else if (frame_wrap) begin
         off_p0      <= x_line;
         off_bidx_p0 <= bidx_line;
         off_bpos_p0 <= bpos_line;
      end
   end
`else
   assign x_line    = '0;
   assign bidx_line = '0;
   assign bpos_line = '0;
`endif

   // Stage p0: decode of the current counter state.
   assign run_p0    = (state == RUN);
   assign active_p0 = run_p0 && (h_p0 < H_ACT) && (v_p0 < V_ACT);
   assign hs_on_p0  = run_p0 && (h_p0 >= HS_BEG) && (h_p0 < HS_END);
   assign vs_on_p0  = run_p0 && (v_p0 >= VS_BEG) && (v_p0 < VS_END);
   assign fs_p0     = run_p0 && (h_p0 == '0) && (v_p0 == '0);
   assign pix_p0    = pattern(mode_sh, fill_sh, x_p0, v_p0, bidx_p0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         h_p0     <= '0;
         v_p0     <= '0;
         x_p0     <= '0;
         bidx_p0  <= '0;
         bpos_p0  <= '0;
         mode_sh  <= '0;
         fill_sh  <= '0;
         red_p1   <= '0;
         green_p1 <= '0;
         blue_p1  <= '0;
         vld_p1   <= 1'b0;
         fs_p1    <= 1'b0;
         hs_p1    <= ~SYNC_ACT;
         vs_p1    <= ~SYNC_ACT;
      end else begin
         // Stage p1: registered outputs, one clock behind the counters.
         {red_p1, green_p1, blue_p1} <= active_p0 ? pix_p0 : '0;
         vld_p1 <= active_p0;
         fs_p1  <= fs_p0;
         hs_p1  <= hs_on_p0 ? SYNC_ACT : ~SYNC_ACT;
         vs_p1  <= vs_on_p0 ? SYNC_ACT : ~SYNC_ACT;

         case (state)
            IDLE: begin
               h_p0    <= '0;
               v_p0    <= '0;
               x_p0    <= '0;
               bidx_p0 <= '0;
               bpos_p0 <= '0;
               if (start) begin
                  state   <= RUN;
                  mode_sh <= mode;
                  fill_sh <= fill;
               end
            end
            RUN: begin
               if (h_p0 == H_LAST) begin
                  h_p0    <= '0;
                  x_p0    <= x_line;
                  bidx_p0 <= bidx_line;
                  bpos_p0 <= bpos_line;
                  if (v_p0 == V_LAST) begin
                     v_p0    <= '0;
                     mode_sh <= mode;
                     fill_sh <= fill;
                     if (!start) begin
                        state   <= IDLE;
                        x_p0    <= '0;
                        bidx_p0 <= '0;
                        bpos_p0 <= '0;
                     end
                  end else begin
                     v_p0 <= v_p0 + CW'(1);
                  end
               end else begin
                  h_p0               <= h_p0 + CW'(1);
                  x_p0               <= x_step(x_p0);
                  {bidx_p0, bpos_p0} <= bar_step(bidx_p0, bpos_p0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign red         = red_p1;
   assign green       = green_p1;
   assign blue        = blue_p1;
   assign de          = vld_p1;
   assign frame_start = fs_p1;
   assign hsync_out   = hs_p1;
   assign vsync       = vs_p1;

endmodule

// File: doc/dvi_pattern_gen.md
# dvi_pattern_gen

Parametrised DVI/VGA timing and test-pattern source. It generates programmable horizontal and vertical blanking and sync timing, plus four selectable RGB patterns. It is the generalised successor to the fixed-resolution stimulus generator. It sits in front of the DVI transmitter encoder, or drives simulation frame dumps directly. Frames start and stop on a `start` level and are always completed whole.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line; must be a multiple of 8.
- `H_FP`, `H_SYNC`, `H_BP`, 16 / 96 / 48: horizontal front porch, sync and back porch widths in clocks; each ≥1.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, `V_SYNC`, `V_BP`, 10 / 2 / 33: vertical porch and sync widths in lines; each ≥1.
- `COLOR_W`, 8: bits per colour channel.
- `SYNC_POL`, 0: 0 means sync is active-low; 1 means sync is active-high.
- `CHK_LOG2`, 3: checkerboard square size is 2^CHK_LOG2 pixels.

Ports:
- `clock`, in, 1: pixel clock; all logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level; high means run frames.
- `mode`, in, 2: 0 = solid, 1 = colour bars, 2 = checkerboard, 3 = horizontal gradient.
- `fill`, in, 3*COLOR_W: solid colour {R,G,B}.
- `red`, `green`, `blue`, out, COLOR_W each: pixel data; forced to 0 outside the active region.
- `hsync_out`, `vsync`, out, 1 each: sync outputs at `SYNC_POL` polarity.
- `de`, out, 1: data enable, high during the active region.
- `frame_start`, out, 1: one-cycle pulse coincident with pixel (0,0).

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Counter `h` runs 0..H_TOTAL-1 and `v` runs 0..V_TOTAL-1.
- Line and frame wrap:
  - `h` wraps to 0 at H_TOTAL-1; `v` increments on that same cycle.
  - `v` wraps to 0 at V_TOTAL-1 when `h` also wraps.
- Region decode:
  - Active region: h<H_ACTIVE and v<V_ACTIVE.
  - hsync is active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- State machine:
  - IDLE: counters held at 0; outputs at reset values. Leave to RUN on the first edge at which `start`=1.
  - RUN: counters advance every clock. At the frame wrap (h=H_TOTAL-1, v=V_TOTAL-1):
    - if `start`=0, go to IDLE;
    - otherwise continue with the next frame.
  - Deasserting `start` mid-frame never truncates the frame.
- `mode` and `fill` are sampled into shadow registers on entry to RUN and at every frame wrap. Changes mid-frame have no effect until the next frame.
- Patterns, with x=h and y=v (or x offset by scroll, see Configuration):
  - Solid: the `fill` shadow value.
  - Bars: 8 bars of width H_ACTIVE/8, tracked by a bar counter (no divider). Order: white, yellow, cyan, green, magenta, red, blue, black. Full scale is all-ones.
  - Checkerboard: white if ((x^y)>>CHK_LOG2)&1 is 0, otherwise black.
  - Gradient: R=G=B=x[COLOR_W-1:0].
- Reset values: RGB=0, `de`=0, `frame_start`=0, and both syncs at their inactive level (1 when SYNC_POL=0). The state machine returns to IDLE.

## Timing
- All outputs are registered. Outputs at edge k+1 reflect the counter state at edge k, giving one clock of latency.
- `start` is sampled high at edge k (IDLE→RUN); counters are (0,0) after edge k. `de`=1, `frame_start`=1 and the first pixel appear after edge k+1.
- An asynchronous `reset_n` low mid-frame forces the reset values immediately. The generator restarts from (0,0) only after release and a sampled `start`.
- Per frame, `de` is high for exactly H_ACTIVE×V_ACTIVE cycles and hsync is active for exactly H_SYNC cycles per line.

## Configuration
- `DVI_PATTERN_SCROLL_EN`:
  - Defined: adds an x offset register (width ≥ log2(H_ACTIVE)) that increments by 1 at each frame wrap, modulo H_ACTIVE, and resets to 0 in IDLE. Patterns use x=(h+offset) mod H_ACTIVE, so bars, checkerboard and gradient scroll left one pixel per frame.
  - Undefined: x=h, and the patterns are static.

## Test plan
Common parameters for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); SYNC_POL=0; COLOR_W=8.
- Reset, then `start`=1 → `de` first high one clock after `start` is sampled. Per line: 16 `de` cycles, then hsync low for 3 cycles starting 2 cycles after `de` falls. vsync low for line 5 only. `frame_start` pulses every 168 cycles.
- Mode 1 → pixel pairs read FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. RGB=0 whenever `de`=0.
- Mode 3 with CHK_LOG2=1; change `mode` to 2 mid-frame → the current frame stays a gradient (R=G=B=0..15). The next frame is a checkerboard: line 0 pixels read W,W,K,K; line 2 starts K.
- Drop `start` during line 2 → the frame completes its full 168 cycles, then the outputs hold reset values with no further `frame_start` pulse.
- Drive `reset_n` low mid-line → syncs go high and RGB/`de` go 0 with no clock edge. After release, nothing happens until `start` is sampled.
- With `DVI_PATTERN_SCROLL_EN` in mode 3 → frame n line 0, pixel 0 equals n mod 16.
